// File: rtl/cacheline_burst_adaptor_pkg.sv
// rtl/cacheline_burst_adaptor_pkg.sv - shared types for the cacheline <-> burst memory adaptor
package cacheline_burst_adaptor_pkg;

    localparam int CL_LINE_W  = 256;
    localparam int CL_BURST_W = 64;

    typedef logic [CL_LINE_W-1:0]  cacheline_t;
    typedef logic [CL_BURST_W-1:0] burst_word_t;

    typedef enum logic [1:0] {
        ADP_IDLE,
        ADP_READ,
        ADP_WRITE,
        ADP_DONE
    } adaptor_state_t;

endpackage

// File: rtl/cacheline_burst_adaptor.sv
// rtl/cacheline_burst_adaptor.sv - serialises/reassembles one cacheline as BEATS memory bursts
module cacheline_burst_adaptor
    import cacheline_burst_adaptor_pkg::*;
#(
    parameter int LINE_W  = CL_LINE_W,
    parameter int BURST_W = CL_BURST_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    localparam int BEATS  = LINE_W / BURST_W;
    localparam int CNT_W  = $clog2(BEATS);
    localparam int OFFS_W = $clog2(LINE_W / 8);

    adaptor_state_t     state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LINE_W-1:0]  buf_q, buf_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic [31:0]        addr_q, addr_d;

    logic unused_addr_bits;
    assign unused_addr_bits = ^address_i[OFFS_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ADP_IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
            line_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            line_q  <= line_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        line_d  = line_q;
        addr_d  = addr_q;
        read_o  = 1'b0;
        write_o = 1'b0;
        resp_o  = 1'b0;
        burst_o = '0;
        unique case (state_q)
            ADP_IDLE: begin
                // write-back takes priority so a dirty victim leaves before its fill arrives
                if (write_i) begin
                    state_d = ADP_WRITE;
                    addr_d  = {address_i[31:OFFS_W], {OFFS_W{1'b0}}};
                    buf_d   = line_i;
                    cnt_d   = '0;
                end else if (read_i) begin
                    state_d = ADP_READ;
                    addr_d  = {address_i[31:OFFS_W], {OFFS_W{1'b0}}};
                    cnt_d   = '0;
                end
            end
            ADP_READ: begin
                read_o = 1'b1;
                if (resp_i) begin
                    buf_d[int'(cnt_q)*BURST_W +: BURST_W] = burst_i;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(BEATS-1)) begin
                        state_d = ADP_DONE;
                        line_d  = buf_d;
                    end
                end
            end
            ADP_WRITE: begin
                write_o = 1'b1;
                burst_o = buf_q[int'(cnt_q)*BURST_W +: BURST_W];
                if (resp_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(BEATS-1)) begin
                        state_d = ADP_DONE;
                    end
                end
            end
            ADP_DONE: begin
                resp_o  = 1'b1;
                state_d = ADP_IDLE;
            end
            default: state_d = ADP_IDLE;
        endcase
    end

    assign line_o    = line_q;
    assign address_o = addr_q;

endmodule
